// File: rtl/rom_loader_if.sv
// Shared types and the stream/ROM bus bundle for rom_loader.
// rom_loader_pkg is kept here so it is compiled before the interface and the loader.
package rom_loader_pkg;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_DONE = 2'd2
    } ram_state_t;
endpackage

interface rom_loader_if;
    import rom_loader_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    word_t             ram_addr;
    word_t             ram_store;
    logic              ram_wen;
    logic              ram_ren;
    ram_state_t        ram_state;

    modport master (
        input  rx_data, rx_valid, ram_state,
        output rx_ready, ram_addr, ram_store, ram_wen, ram_ren
    );

    modport slave (
        output rx_data, rx_valid, ram_state,
        input  rx_ready, ram_addr, ram_store, ram_wen, ram_ren
    );
endinterface

// File: rtl/rom_loader.sv
// Boot loader: header word count, then N little-endian words written to consecutive ROM addresses.
// Optional trailer checksum compiled in with ROM_LOADER_CHECKSUM_EN.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter word_t       BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    rom_loader_if.master     bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output word_t            words_written
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_WRITE, S_WAIT, S_CSUM, S_DONE, S_ERR
    } state_t;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = S_CSUM;
`else
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_q, word_d;
    word_t       count_q, count_d;
    word_t       ww_q, ww_d;
    word_t       ram_addr_q, ram_addr_d;
    word_t       ram_store_q, ram_store_d;
    logic        ram_wen_q, ram_wen_d;
    logic        rx_ready_q, rx_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
`ifdef ROM_LOADER_CHECKSUM_EN
    word_t       csum_q, csum_d;
`endif

    logic  accept;
    logic  last_byte;
    word_t full_word;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        count_d     = count_q;
        ww_d        = ww_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;
        ram_wen_d   = ram_wen_q;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        accept    = bus.rx_valid && rx_ready_q;
        last_byte = (byte_idx_q == 2'd3);
        full_word = {bus.rx_data, word_q};

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR;
                    ww_d       = '0;
                    byte_idx_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_HDR, S_DATA, S_CSUM: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    word_d[7:0]   = bus.rx_data;
                        2'd1:    word_d[15:8]  = bus.rx_data;
                        2'd2:    word_d[23:16] = bus.rx_data;
                        default: ;
                    endcase
                    if (last_byte) begin
                        if (state_q == S_HDR) begin
                            count_d = full_word;
                            if (full_word > 32'(MAX_WORDS))
                                state_d = S_ERR;
                            else if (full_word == '0)
                                state_d = S_AFTER_LAST;
                            else
                                state_d = S_DATA;
                        end else if (state_q == S_DATA) begin
                            state_d     = S_WRITE;
                            ram_wen_d   = 1'b1;
                            ram_addr_d  = BASE_ADDR + {ww_q[29:0], 2'b00};
                            ram_store_d = full_word;
`ifdef ROM_LOADER_CHECKSUM_EN
                            csum_d      = csum_q + full_word;
`endif
                        end else begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            state_d = (full_word == csum_q) ? S_DONE : S_ERR;
`else
                            state_d = S_ERR;
`endif
                        end
                    end
                end
            end
            // wen is guaranteed across the edge that ends WRITE
            S_WRITE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.ram_state != RAM_WAIT) begin
                    ram_wen_d = 1'b0;
                    ww_d      = ww_q + 32'd1;
                    state_d   = ((ww_q + 32'd1) < count_q) ? S_DATA : S_AFTER_LAST;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
        busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= '0;
            word_q      <= '0;
            count_q     <= '0;
            ww_q        <= '0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
            ram_wen_q   <= 1'b0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            count_q     <= count_d;
            ww_q        <= ww_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
            ram_wen_q   <= ram_wen_d;
            rx_ready_q  <= rx_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_store  = ram_store_q;
    assign bus.ram_wen    = ram_wen_q;
    assign bus.ram_ren    = 1'b0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_written  = ww_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: ROM handshake model, stream driver and outcome/write-log reference model.
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam word_t       BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 1024;

    logic  clk = 1'b0;
    logic  nrst = 1'b0;
    logic  start = 1'b0;
    logic  busy, done, error;
    word_t words_written;

    rom_loader_if bus();

    rom_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .bus           (bus.master),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ROM model: captures a write when idle, then RAM_WAIT for rom_wait cycles
    int    rom_wait = 2;
    int    rom_cnt;
    word_t mem [word_t];
    word_t wr_addr_q[$];
    word_t wr_data_q[$];

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.ram_state <= RAM_IDLE;
            rom_cnt       <= 0;
        end else begin
            case (bus.ram_state)
                RAM_IDLE: if (bus.ram_wen) begin
                    mem[bus.ram_addr] = bus.ram_store;
                    wr_addr_q.push_back(bus.ram_addr);
                    wr_data_q.push_back(bus.ram_store);
                    if (rom_wait == 0) bus.ram_state <= RAM_DONE;
                    else begin
                        bus.ram_state <= RAM_WAIT;
                        rom_cnt       <= rom_wait;
                    end
                end
                RAM_WAIT: begin
                    if (rom_cnt <= 1) bus.ram_state <= RAM_DONE;
                    rom_cnt <= rom_cnt - 1;
                end
                RAM_DONE: if (!bus.ram_wen) bus.ram_state <= RAM_IDLE;
                default:  bus.ram_state <= RAM_IDLE;
            endcase
        end
    end

    // Protocol watch: no byte accept while writing, write bus frozen while wen is held
    word_t prev_addr, prev_store;
    logic  prev_wen;
    always @(negedge clk) begin
        if (bus.ram_wen) begin
            vectors++;
            if (bus.rx_ready) begin
                miscompares++;
                $display("FAIL rdy_during_write: rx_ready=%0b required 0", bus.rx_ready);
            end
            if (prev_wen) begin
                vectors++;
                if (bus.ram_addr !== prev_addr || bus.ram_store !== prev_store) begin
                    miscompares++;
                    $display("FAIL wen_stable: addr=%h store=%h required addr=%h store=%h",
                             bus.ram_addr, bus.ram_store, prev_addr, prev_store);
                end
            end
        end
        prev_wen   <= bus.ram_wen;
        prev_addr  <= bus.ram_addr;
        prev_store <= bus.ram_store;
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  budget = 0;
        bit  sent = 0;
        while (!sent) begin
            bus.rx_data  = b;
            bus.rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.rx_valid && bus.rx_ready) sent = 1;
            @(negedge clk);
            budget++;
            if (!sent && budget > 1000) begin
                vectors++; miscompares++;
                $display("FAIL byte_timeout: byte %h never accepted, required acceptance", b);
                bus.rx_valid = 1'b0;
                return;
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input word_t w, input bit rnd);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], rnd);
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (busy && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (busy) begin
            vectors++; miscompares++;
            $display("FAIL idle_timeout: busy=%0b required 0", busy);
        end
    endtask

    // Reference: outcome and write log follow directly from header, payload and trailer
    task automatic run_load(input word_t n, input word_t words[$], input bit bad_trailer, input bit rnd);
        bit    hdr_err = (n > word_t'(MAXW));
        bit    exp_err = hdr_err;
        word_t sum = '0;
        word_t exp_ww = hdr_err ? '0 : n;
        foreach (words[i]) sum += words[i];
`ifdef ROM_LOADER_CHECKSUM_EN
        if (!hdr_err && bad_trailer) exp_err = 1'b1;
`endif
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_word(n, rnd);
        if (!hdr_err) begin
            foreach (words[i]) send_word(words[i], rnd);
`ifdef ROM_LOADER_CHECKSUM_EN
            send_word(bad_trailer ? sum + 32'd1 : sum, rnd);
`endif
        end
        wait_idle();
        @(negedge clk);
        vectors++;
        if (done !== !exp_err || error !== exp_err) begin
            miscompares++;
            $display("FAIL outcome n=%0d: done=%0b error=%0b required done=%0b error=%0b",
                     n, done, error, !exp_err, exp_err);
        end
        vectors++;
        if (words_written !== exp_ww) begin
            miscompares++;
            $display("FAIL words_written n=%0d: got %0d required %0d", n, words_written, exp_ww);
        end
        vectors++;
        if (wr_addr_q.size() !== int'(exp_ww)) begin
            miscompares++;
            $display("FAIL write_count n=%0d: got %0d required %0d", n, wr_addr_q.size(), exp_ww);
        end
        for (int i = 0; i < wr_addr_q.size() && i < int'(exp_ww); i++) begin
            vectors++;
            if (wr_addr_q[i] !== BASE + word_t'(4 * i) || wr_data_q[i] !== words[i]) begin
                miscompares++;
                $display("FAIL write[%0d]: addr=%h data=%h required addr=%h data=%h",
                         i, wr_addr_q[i], wr_data_q[i], BASE + word_t'(4 * i), words[i]);
            end
            vectors++;
            if (!mem.exists(BASE + word_t'(4 * i)) || mem[BASE + word_t'(4 * i)] !== words[i]) begin
                miscompares++;
                $display("FAIL readback[%0d]: required %h", i, words[i]);
            end
        end
        vectors++;
        if (bus.rx_ready !== 1'b0 || bus.ram_wen !== 1'b0 || bus.ram_ren !== 1'b0) begin
            miscompares++;
            $display("FAIL quiet_after n=%0d: rx_ready=%0b wen=%0b ren=%0b required 0 0 0",
                     n, bus.rx_ready, bus.ram_wen, bus.ram_ren);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({bus.rx_ready, bus.ram_wen, bus.ram_ren, busy, done, error} !== 6'b0 ||
            words_written !== '0 || bus.ram_addr !== '0 || bus.ram_store !== '0) begin
            miscompares++;
            $display("FAIL %s: rdy=%0b wen=%0b ren=%0b busy=%0b done=%0b err=%0b ww=%0d addr=%h store=%h required all 0",
                     tag, bus.rx_ready, bus.ram_wen, bus.ram_ren, busy, done, error,
                     words_written, bus.ram_addr, bus.ram_store);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        nrst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_release");
    endtask

    task automatic test_basic();
        word_t w[$] = '{32'hDEADBEEF, 32'h0000_0004};
        rom_wait = 2;
        run_load(32'd2, w, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        wr_addr_q.delete();
        pulse_start();
        send_word(32'd0, 1'b0);
`ifdef ROM_LOADER_CHECKSUM_EN
        vectors++;
        if (done !== 1'b0 || bus.rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_trailer_wait: done=%0b rdy=%0b required 0 1", done, bus.rx_ready);
        end
        send_word(32'd0, 1'b0);
`endif
        vectors++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: done=%0b error=%0b busy=%0b required 1 0 0", done, error, busy);
        end
        vectors++;
        if (wr_addr_q.size() !== 0 || words_written !== '0) begin
            miscompares++;
            $display("FAIL zero_writes: writes=%0d ww=%0d required 0 0", wr_addr_q.size(), words_written);
        end
    endtask

    task automatic test_overflow();
        word_t w[$];
        run_load(word_t'(MAXW + 1), w, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        word_t w[$];
        for (int i = 0; i < 4; i++) w.push_back($urandom);
        rom_wait = 5;
        run_load(32'd4, w, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            word_t w[$];
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            rom_wait = $urandom_range(0, 3);
            run_load(word_t'(n), w, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_wait();
        word_t w[$];
        int budget = 0;
        rom_wait = 5;
        pulse_start();
        send_word(32'd3, 1'b0);
        send_word(32'h1111_1111, 1'b0);
        send_word(32'h2222_2222, 1'b0);
        while (!(bus.ram_wen && bus.ram_state == RAM_WAIT) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        vectors++;
        if (!(bus.ram_wen && bus.ram_state == RAM_WAIT) || words_written !== 32'd1) begin
            miscompares++;
            $display("FAIL mid_wait_reach: wen=%0b ww=%0d required 1 1", bus.ram_wen, words_written);
        end
        #1 nrst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        w.push_back(32'hCAFE_F00D);
        rom_wait = 1;
        run_load(32'd1, w, 1'b0, 1'b0);
    endtask

`ifdef ROM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        word_t w[$] = '{32'd1, 32'd2};
        rom_wait = 1;
        run_load(32'd2, w, 1'b0, 1'b0);
        run_load(32'd2, w, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef ROM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
